// File: rtl/output_preprocessor.sv
// Per-channel gain / shift / offset / clamp post-processor for router output frames.
// Channels are issued serially through a 3-stage pipeline and released together from a holding bank.
module output_preprocessor #(
  parameter int W_CHAN = 16,
  parameter int W_SEL  = 4,
  parameter int N_OUT  = 8,
  parameter int W_MULT = 16,
  parameter int W_RS   = 5
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [W_CHAN*N_OUT-1:0] data_bus_in,
  input  logic                    data_valid_in,
  input  logic [W_SEL-1:0]        chan_select_in,
  input  logic [W_MULT-1:0]       mult_in,
  input  logic [W_RS-1:0]         rs_in,
  input  logic [W_CHAN-1:0]       offset_in,
  input  logic [W_CHAN-1:0]       min_in,
  input  logic [W_CHAN-1:0]       max_in,
  input  logic                    update_in,
  output logic [W_CHAN*N_OUT-1:0] data_bus_out,
  output logic                    data_valid_out,
  output logic                    busy_out,
  output logic                    overrun_out
);

  localparam int W_P   = W_CHAN + W_MULT;
  localparam int W_S   = W_P + 1;
  localparam int W_IDX = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [W_IDX-1:0]  LAST     = W_IDX'(N_OUT - 1);
  localparam logic [W_CHAN-1:0] MIN_RST  = {1'b1, {(W_CHAN-1){1'b0}}};
  localparam logic [W_CHAN-1:0] MAX_RST  = {1'b0, {(W_CHAN-1){1'b1}}};
  localparam logic [W_MULT-1:0] MULT_RST = W_MULT'(1);

  typedef enum logic [1:0] {IDLE, PROC, DRAIN} state_t;
  state_t state, state_nxt;

  logic [W_IDX-1:0]  ch_cnt;
  logic [1:0]        drain_cnt;
  logic              capture;
  logic [N_OUT-1:0]  upd_hit;

  logic [W_MULT-1:0] sh_mult [N_OUT];
  logic [W_RS-1:0]   sh_rs   [N_OUT];
  logic [W_CHAN-1:0] sh_off  [N_OUT];
  logic [W_CHAN-1:0] sh_min  [N_OUT];
  logic [W_CHAN-1:0] sh_max  [N_OUT];
  logic [W_MULT-1:0] act_mult[N_OUT];
  logic [W_RS-1:0]   act_rs  [N_OUT];
  logic [W_CHAN-1:0] act_off [N_OUT];
  logic [W_CHAN-1:0] act_min [N_OUT];
  logic [W_CHAN-1:0] act_max [N_OUT];
  logic [W_CHAN-1:0] data_reg[N_OUT];
  logic [W_CHAN-1:0] bank    [N_OUT];

  logic                    s1_valid, s2_valid, bank_done;
  logic [W_IDX-1:0]        s1_idx, s2_idx;
  logic signed [W_P-1:0]   s1_p, x_ext, m_ext, prod;
  logic signed [W_S-1:0]   s2_s, p_ext, off_ext, sum, mx_ext, mn_ext, lim_hi, lim_lo;
  logic [W_CHAN-1:0]       res;

  // Busy spans the output pulse so a frame arriving on that cycle is dropped too.
  assign busy_out = (state != IDLE) || data_valid_out;
  assign capture  = data_valid_in && !busy_out;

  always_comb begin
    upd_hit = '0;
    for (int unsigned i = 0; i < N_OUT; i++)
      upd_hit[i] = update_in && (chan_select_in == W_SEL'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = PROC;
      PROC:    if (ch_cnt == LAST) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state       <= IDLE;
      ch_cnt      <= '0;
      drain_cnt   <= '0;
      overrun_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch_cnt    <= capture ? '0 : (state == PROC) ? ch_cnt + 1'b1 : ch_cnt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      if (data_valid_in && busy_out) overrun_out <= 1'b1;
    end
  end

  // A write coinciding with capture is forwarded straight into the active copy.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        sh_mult[i]  <= MULT_RST; sh_rs[i]  <= '0; sh_off[i]  <= '0;
        sh_min[i]   <= MIN_RST;  sh_max[i] <= MAX_RST;
        act_mult[i] <= MULT_RST; act_rs[i] <= '0; act_off[i] <= '0;
        act_min[i]  <= MIN_RST;  act_max[i] <= MAX_RST;
        data_reg[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_OUT; i++) begin
        if (upd_hit[i]) begin
          sh_mult[i] <= mult_in; sh_rs[i]  <= rs_in; sh_off[i] <= offset_in;
          sh_min[i]  <= min_in;  sh_max[i] <= max_in;
        end
        if (capture) begin
          act_mult[i] <= upd_hit[i] ? mult_in   : sh_mult[i];
          act_rs[i]   <= upd_hit[i] ? rs_in     : sh_rs[i];
          act_off[i]  <= upd_hit[i] ? offset_in : sh_off[i];
          act_min[i]  <= upd_hit[i] ? min_in    : sh_min[i];
          act_max[i]  <= upd_hit[i] ? max_in    : sh_max[i];
          data_reg[i] <= data_bus_in[i*W_CHAN +: W_CHAN];
        end
      end
    end
  end

  always_comb begin
    x_ext   = {{W_MULT{data_reg[ch_cnt][W_CHAN-1]}}, data_reg[ch_cnt]};
    m_ext   = {{W_CHAN{act_mult[ch_cnt][W_MULT-1]}}, act_mult[ch_cnt]};
    prod    = x_ext * m_ext;
    p_ext   = {s1_p[W_P-1], s1_p};
    off_ext = {{(W_S-W_CHAN){act_off[s1_idx][W_CHAN-1]}}, act_off[s1_idx]};
    sum     = (p_ext >>> act_rs[s1_idx]) + off_ext;
    mx_ext  = {{(W_S-W_CHAN){act_max[s2_idx][W_CHAN-1]}}, act_max[s2_idx]};
    mn_ext  = {{(W_S-W_CHAN){act_min[s2_idx][W_CHAN-1]}}, act_min[s2_idx]};
    // Min is applied after max so an inverted window resolves to min.
    lim_hi  = (s2_s > mx_ext) ? mx_ext : s2_s;
    lim_lo  = (lim_hi < mn_ext) ? mn_ext : lim_hi;
    res     = lim_lo[W_CHAN-1:0];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_valid       <= 1'b0;
      s1_idx         <= '0;
      s1_p           <= '0;
      s2_valid       <= 1'b0;
      s2_idx         <= '0;
      s2_s           <= '0;
      bank_done      <= 1'b0;
      data_valid_out <= 1'b0;
      data_bus_out   <= '0;
      for (int unsigned i = 0; i < N_OUT; i++) bank[i] <= '0;
    end else begin
      s1_valid       <= (state == PROC);
      s1_idx         <= ch_cnt;
      s1_p           <= prod;
      s2_valid       <= s1_valid;
      s2_idx         <= s1_idx;
      s2_s           <= sum;
      if (s2_valid) bank[s2_idx] <= res;
      bank_done      <= s2_valid && (s2_idx == LAST);
      data_valid_out <= bank_done;
      if (bank_done)
        for (int unsigned i = 0; i < N_OUT; i++) data_bus_out[i*W_CHAN +: W_CHAN] <= bank[i];
    end
  end

endmodule

// File: tb/tb_output_preprocessor.sv
// Scoreboard bench for output_preprocessor: expected frames are queued at capture
// and compared when data_valid_out pulses.
module tb_output_preprocessor;
  localparam int W   = 16;
  localparam int N   = 8;
  localparam int BUS = W * N;
  localparam int LAT = N + 3;

  logic           clk_in = 1'b0;
  logic           rst_n_in = 1'b0;
  logic [BUS-1:0] data_bus_in = '0;
  logic           data_valid_in = 1'b0;
  logic [3:0]     chan_select_in = '0;
  logic [15:0]    mult_in = '0;
  logic [4:0]     rs_in = '0;
  logic [15:0]    offset_in = '0, min_in = '0, max_in = '0;
  logic           update_in = 1'b0;
  logic [BUS-1:0] data_bus_out;
  logic           data_valid_out, busy_out, overrun_out;

  output_preprocessor #(.W_CHAN(W), .W_SEL(4), .N_OUT(N), .W_MULT(16), .W_RS(5)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .data_bus_in(data_bus_in), .data_valid_in(data_valid_in),
    .chan_select_in(chan_select_in), .mult_in(mult_in), .rs_in(rs_in), .offset_in(offset_in),
    .min_in(min_in), .max_in(max_in), .update_in(update_in), .data_bus_out(data_bus_out),
    .data_valid_out(data_valid_out), .busy_out(busy_out), .overrun_out(overrun_out));

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  logic [BUS-1:0] exp_q[$];
  int m_mult[N], m_rs[N], m_off[N], m_min[N], m_max[N];

  function automatic logic [BUS-1:0] model_frame(input logic [BUS-1:0] bus);
    logic [BUS-1:0] o;
    logic signed [15:0] xs;
    longint x, p, s, r;
    o = '0;
    for (int i = 0; i < N; i++) begin
      xs = bus[i*W +: W];
      x  = longint'(xs);
      p  = x * longint'(m_mult[i]);
      s  = (p >>> m_rs[i]) + longint'(m_off[i]);
      r  = (s > longint'(m_max[i])) ? longint'(m_max[i]) : s;
      r  = (r < longint'(m_min[i])) ? longint'(m_min[i]) : r;
      o[i*W +: W] = r[15:0];
    end
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mult[i] = 1; m_rs[i] = 0; m_off[i] = 0; m_min[i] = -32768; m_max[i] = 32767;
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_update(input int ch, input int mult, input int rs, input int off,
                            input int mn, input int mx);
    chan_select_in = 4'(ch); mult_in = 16'(mult); rs_in = 5'(rs);
    offset_in = 16'(off); min_in = 16'(mn); max_in = 16'(mx); update_in = 1'b1;
    if (ch < N) begin
      m_mult[ch] = 32'(signed'(16'(mult))); m_rs[ch] = rs & 31;
      m_off[ch] = 32'(signed'(16'(off))); m_min[ch] = 32'(signed'(16'(mn)));
      m_max[ch] = 32'(signed'(16'(mx)));
    end
  endtask

  task automatic write_param(input int ch, input int mult, input int rs, input int off,
                             input int mn, input int mx);
    set_update(ch, mult, rs, off, mn, mx);
    tick();
    update_in = 1'b0;
  endtask

  // Drives one frame and waits (bounded) for its output; ends one cycle after the pulse.
  task automatic run_frame(input logic [BUS-1:0] bus, output logic [BUS-1:0] obs,
                           output int lat, output logic busy0, output logic busy_end);
    data_bus_in = bus; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0; update_in = 1'b0;
    busy0 = busy_out; lat = -1; obs = '0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (data_valid_out) begin lat = k; obs = data_bus_out; break; end
    end
    tick();
    busy_end = busy_out;
  endtask

  function automatic logic [BUS-1:0] rand_bus();
    logic [BUS-1:0] b;
    for (int i = 0; i < N; i++) b[i*W +: W] = 16'($urandom);
    return b;
  endfunction

  task automatic check_frame(input string name, input logic [BUS-1:0] obs, input int lat);
    logic [BUS-1:0] e;
    e = exp_q.pop_front();
    total++;
    if (lat !== LAT) begin bad++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT); end
    total++;
    if (obs !== e) begin bad++; $display("FAIL %s_data: got %h expected %h", name, obs, e); end
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (3) tick();
    total++; if (data_bus_out !== '0) begin bad++; $display("FAIL rst_bus: got %h expected 0", data_bus_out); end
    total++; if (data_valid_out !== 1'b0) begin bad++; $display("FAIL rst_dv: got %b expected 0", data_valid_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b expected 0", busy_out); end
    total++; if (overrun_out !== 1'b0) begin bad++; $display("FAIL rst_ovr: got %b expected 0", overrun_out); end
    rst_n_in = 1'b1;
    model_reset();
    tick();
  endtask

  task automatic test_passthrough();
    logic [BUS-1:0] bus, obs; int lat; logic b0, b1;
    bus = {N{16'h1234}};
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    total++; if (b0 !== 1'b1) begin bad++; $display("FAIL pass_busy_start: got %b expected 1", b0); end
    total++; if (b1 !== 1'b0) begin bad++; $display("FAIL pass_busy_end: got %b expected 0", b1); end
    total++; if (obs !== {N{16'h1234}}) begin bad++; $display("FAIL pass_const: got %h expected all 1234", obs); end
    check_frame("pass", obs, lat);
  endtask

  task automatic test_gain();
    logic [BUS-1:0] bus, obs, want; int lat; logic b0, b1;
    write_param(2, 3, 1, 100, -32768, 32767);
    bus = {N{16'd1000}};
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    want = {N{16'd1000}};
    want[2*W +: W] = 16'd1600;
    total++; if (obs !== want) begin bad++; $display("FAIL gain_ch2: got %h expected %h", obs, want); end
    check_frame("gain", obs, lat);
  endtask

  task automatic test_clamp();
    logic [BUS-1:0] bus, obs; int lat; logic b0, b1;
    write_param(0, 1, 0, 0, -32768, 500);
    write_param(1, 1, 0, 0, -200, 32767);
    bus = rand_bus();
    bus[0 +: W] = 16'd1000;
    bus[W +: W] = 16'h8000;
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    total++; if (obs[0 +: W] !== 16'd500) begin bad++; $display("FAIL clamp_max: got %h expected 01f4", obs[0 +: W]); end
    total++; if (obs[W +: W] !== 16'hff38) begin bad++; $display("FAIL clamp_min: got %h expected ff38", obs[W +: W]); end
    check_frame("clamp", obs, lat);
  endtask

  task automatic test_rounding();
    logic [BUS-1:0] bus, obs; int lat; logic b0, b1;
    write_param(4, 1, 1, 0, -32768, 32767);
    write_param(5, 1, 0, 0, 100, -100);
    write_param(9, 7, 3, 55, 0, 0);
    write_param(15, 2, 2, 9, 1, 1);
    bus = rand_bus();
    bus[4*W +: W] = 16'hfff9;
    bus[5*W +: W] = 16'h0000;
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    total++; if (obs[4*W +: W] !== 16'hfffc) begin bad++; $display("FAIL round_floor: got %h expected fffc", obs[4*W +: W]); end
    total++; if (obs[5*W +: W] !== 16'd100) begin bad++; $display("FAIL min_gt_max: got %h expected 0064", obs[5*W +: W]); end
    check_frame("round", obs, lat);
  endtask

  task automatic test_update_coincident();
    logic [BUS-1:0] bus, obs; int lat; logic b0, b1;
    bus = rand_bus();
    bus[6*W +: W] = 16'd300;
    set_update(6, 2, 0, 7, -32768, 32767);
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    total++; if (obs[6*W +: W] !== 16'd607) begin bad++; $display("FAIL coinc_ch6: got %h expected 025f", obs[6*W +: W]); end
    check_frame("coinc", obs, lat);
  endtask

  task automatic test_overrun();
    logic [BUS-1:0] b1, obs; int lat, np; logic x0, x1;
    b1 = rand_bus();
    b1[3*W +: W] = 16'd50;
    exp_q.push_back(model_frame(b1));
    data_bus_in = b1; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    lat = -1; obs = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 2) data_bus_in = ~b1;
      if (k == 4) data_valid_in = 1'b1;
      if (k == 5) data_valid_in = 1'b0;
      if (k == 6) set_update(3, 2, 0, 5, -32768, 32767);
      if (k == 7) update_in = 1'b0;
      tick();
      if (data_valid_out) begin lat = k; obs = data_bus_out; break; end
    end
    total++; if (overrun_out !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b expected 1", overrun_out); end
    check_frame("ovr_frame", obs, lat);
    data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    np = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (data_valid_out) np++; end
    total++; if (np !== 0) begin bad++; $display("FAIL ovr_drop: got %0d pulses expected 0", np); end
    b1 = rand_bus();
    b1[3*W +: W] = 16'd50;
    exp_q.push_back(model_frame(b1));
    run_frame(b1, obs, lat, x0, x1);
    total++; if (obs[3*W +: W] !== 16'd105) begin bad++; $display("FAIL deferred_ch3: got %h expected 0069", obs[3*W +: W]); end
    check_frame("deferred", obs, lat);
    total++; if (overrun_out !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b expected 1", overrun_out); end
  endtask

  task automatic test_reset_midframe();
    logic [BUS-1:0] bus, obs; int lat, np; logic b0, b1;
    data_bus_in = rand_bus(); data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    repeat (4) tick();
    rst_n_in = 1'b0;
    #1;
    total++; if (data_bus_out !== '0) begin bad++; $display("FAIL mid_rst_bus: got %h expected 0", data_bus_out); end
    total++; if (busy_out !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b expected 0", busy_out); end
    total++; if (overrun_out !== 1'b0) begin bad++; $display("FAIL mid_rst_ovr: got %b expected 0", overrun_out); end
    repeat (2) tick();
    rst_n_in = 1'b1;
    model_reset();
    np = 0;
    for (int k = 0; k < 20; k++) begin tick(); if (data_valid_out) np++; end
    total++; if (np !== 0) begin bad++; $display("FAIL mid_rst_nopulse: got %0d pulses expected 0", np); end
    bus = {N{16'h0777}};
    exp_q.push_back(model_frame(bus));
    run_frame(bus, obs, lat, b0, b1);
    total++; if (obs !== {N{16'h0777}}) begin bad++; $display("FAIL mid_rst_after: got %h expected all 0777", obs); end
    check_frame("after_rst", obs, lat);
  endtask

  task automatic test_back_to_back();
    logic [BUS-1:0] bus, obs; int lat; logic b0, b1;
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 2; j++)
        write_param(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
      bus = rand_bus();
      exp_q.push_back(model_frame(bus));
      run_frame(bus, obs, lat, b0, b1);
      check_frame("b2b", obs, lat);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_passthrough();
    test_gain();
    test_clamp();
    test_rounding();
    test_update_coincident();
    test_overrun();
    test_reset_midframe();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
